// File: rtl/bus_init_sequencer_if.sv
// Boot-table fetch port and CPU-style address/data/write-strobe bus between
// the init sequencer (master) and the boot ROM / FPGA-mapped target (slave).
interface bus_init_sequencer_if #(
  parameter int unsigned TABLE_AW = 8
);
  logic [TABLE_AW-1:0] table_address;
  logic [23:0]         table_data;
  logic [15:0]         cpu_address;
  logic [7:0]          write_data;
  logic                write_enable_B;
  logic [7:0]          data_out;
  logic                fpga_data_enable;

  modport master (
    output table_address, cpu_address, write_data, write_enable_B,
    input  table_data, data_out, fpga_data_enable
  );

  modport slave (
    input  table_address, cpu_address, write_data, write_enable_B,
    output table_data, data_out, fpga_data_enable
  );
endinterface

// File: rtl/bus_init_sequencer.sv
// Replays a boot table of (addr,data) writes onto the CPU bus while holding the target in reset;
// 4 enabled cycles per entry (6 with read-back verify); clk_enable low freezes every output.
module bus_init_sequencer #(
  parameter int unsigned TABLE_AW   = 8,
  parameter bit          VERIFY     = 1'b0,
  parameter bit          AUTO_START = 1'b1,
  parameter logic [15:0] END_ADDR   = 16'hFFFF
) (
  input  logic                clk_1,
  input  logic                rst_B,
  input  logic                clk_enable,
  input  logic                start,
  bus_init_sequencer_if.master bus,
  output logic                target_rst,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [7:0]          mismatch_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    WRITE,
    READ,
    CHECK,
    NEXT,
    DONE
  } state_t;

  state_t              state;
  logic [TABLE_AW-1:0] index;
  logic [7:0]          rd_sample;
  logic                rd_vld;
  logic [15:0]         entry_addr;
  logic [7:0]          entry_data;
  logic                launch;
  logic                last_entry;
  logic                rd_bad;

  assign entry_addr = bus.table_data[23:8];
  assign entry_data = bus.table_data[7:0];
  assign last_entry = (index == {TABLE_AW{1'b1}});
  assign rd_bad     = !rd_vld || (rd_sample != bus.write_data);

  // IDLE is only ever occupied straight after reset, so AUTO_START alone
  // suffices to fire exactly one sequence per reset release.
  assign launch = ((state == IDLE) && (start || AUTO_START)) ||
                  ((state == DONE) && start);

  always_ff @(posedge clk_1 or negedge rst_B) begin
    if (!rst_B) begin
      state              <= IDLE;
      index              <= '0;
      bus.table_address  <= '0;
      bus.cpu_address    <= '0;
      bus.write_data     <= '0;
      bus.write_enable_B <= 1'b1;
      target_rst         <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      mismatch_count     <= '0;
      rd_sample          <= '0;
      rd_vld             <= 1'b0;
    end else if (clk_enable) begin
      if (launch) begin
        state             <= FETCH;
        index             <= '0;
        bus.table_address <= '0;
        busy              <= 1'b1;
        target_rst        <= 1'b1;
        done              <= 1'b0;
        error             <= 1'b0;
        mismatch_count    <= '0;
      end else begin
        case (state)
          FETCH: begin
            state <= DECODE;
          end
          DECODE: begin
            // Sentinel ends the table without ever touching the bus.
            if (entry_addr == END_ADDR) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              target_rst <= 1'b0;
            end else begin
              bus.cpu_address    <= entry_addr;
              bus.write_data     <= entry_data;
              bus.write_enable_B <= 1'b0;
              state              <= WRITE;
            end
          end
          WRITE: begin
            bus.write_enable_B <= 1'b1;
            state              <= VERIFY ? READ : NEXT;
          end
          READ: begin
            rd_sample <= bus.data_out;
            rd_vld    <= bus.fpga_data_enable;
            state     <= CHECK;
          end
          CHECK: begin
            if (rd_bad && (mismatch_count != 8'hFF))
              mismatch_count <= mismatch_count + 8'd1;
            state <= NEXT;
          end
          NEXT: begin
            if (last_entry) begin
              error      <= 1'b1;
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              target_rst <= 1'b0;
            end else begin
              index             <= index + 1'b1;
              bus.table_address <= index + 1'b1;
              state             <= FETCH;
            end
          end
          default: begin
            // IDLE / DONE without a launch request: hold.
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_init_sequencer.sv
// Directed bench: DUT a (8-bit table, no verify, auto start) and DUT b (2-bit table,
// verify, manual start) each fed by a synchronous ROM model and a write-logging target.
module tb_bus_init_sequencer;

  logic       clk_1 = 1'b0;
  logic       rst_a, rst_b, en_a, en_b, start_a, start_b, fen_b;
  logic       trst_a, busy_a, done_a, err_a;
  logic       trst_b, busy_b, done_b, err_b;
  logic [7:0] mm_a, mm_b;
  int         nvec = 0;
  int         nfail = 0;
  int         n;

  logic [23:0] rom_a [0:255];
  logic [23:0] rom_b [0:3];
  logic [7:0]  tmem_b [0:65535];
  logic [23:0] wlog_a [$];
  logic [23:0] wlog_b [$];
  logic        we_prev_a = 1'b1;
  logic        we_prev_b = 1'b1;
  logic [23:0] exp_a [3] = '{24'h370099, 24'h370147, 24'h3f0000};
  logic [23:0] exp_b [3] = '{24'h3900AA, 24'h390155, 24'h3b0012};

  always #5 clk_1 = ~clk_1;

  bus_init_sequencer_if #(.TABLE_AW(8)) bus_a ();
  bus_init_sequencer_if #(.TABLE_AW(2)) bus_b ();

  bus_init_sequencer #(.TABLE_AW(8), .VERIFY(1'b0), .AUTO_START(1'b1), .END_ADDR(16'hFFFF)) dut_a (
    .clk_1(clk_1), .rst_B(rst_a), .clk_enable(en_a), .start(start_a), .bus(bus_a),
    .target_rst(trst_a), .busy(busy_a), .done(done_a), .error(err_a), .mismatch_count(mm_a)
  );

  bus_init_sequencer #(.TABLE_AW(2), .VERIFY(1'b1), .AUTO_START(1'b0), .END_ADDR(16'hFFFF)) dut_b (
    .clk_1(clk_1), .rst_B(rst_b), .clk_enable(en_b), .start(start_b), .bus(bus_b),
    .target_rst(trst_b), .busy(busy_b), .done(done_b), .error(err_b), .mismatch_count(mm_b)
  );

  // Boot ROMs: data valid one cycle after the address.
  always @(posedge clk_1) bus_a.table_data <= rom_a[bus_a.table_address];
  always @(posedge clk_1) bus_b.table_data <= rom_b[bus_b.table_address];

  // Target b echoes writes, except 0x3901 which always reads 0x00.
  always @(posedge clk_1) if (!bus_b.write_enable_B) tmem_b[bus_b.cpu_address] <= bus_b.write_data;
  assign bus_b.data_out         = (bus_b.cpu_address == 16'h3901) ? 8'h00 : tmem_b[bus_b.cpu_address];
  assign bus_b.fpga_data_enable = fen_b;
  assign bus_a.data_out         = 8'h00;
  assign bus_a.fpga_data_enable = 1'b0;

  // One log entry per falling edge of the write strobe.
  always @(negedge clk_1) begin
    if (!bus_a.write_enable_B && we_prev_a) wlog_a.push_back({bus_a.cpu_address, bus_a.write_data});
    we_prev_a = bus_a.write_enable_B;
    if (!bus_b.write_enable_B && we_prev_b) wlog_b.push_back({bus_b.cpu_address, bus_b.write_data});
    we_prev_b = bus_b.write_enable_B;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int k = 1);
    repeat (k) @(negedge clk_1);
  endtask

  task automatic wait_done(input bit sel_b, output int cnt);
    cnt = 0;
    while (!(sel_b ? done_b : done_a) && cnt < 300) begin
      @(negedge clk_1);
      cnt++;
    end
  endtask

  task automatic check_log_a(input string tag);
    logic [23:0] v;
    check({tag, "_count"}, wlog_a.size(), 3);
    for (int i = 0; i < 3; i++) begin
      v = (i < wlog_a.size()) ? wlog_a[i] : 24'hxxxxxx;
      check($sformatf("%s_w%0d", tag, i), v, exp_a[i]);
    end
  endtask

  task automatic check_log_b(input string tag);
    logic [23:0] v;
    check({tag, "_count"}, wlog_b.size(), 3);
    for (int i = 0; i < 3; i++) begin
      v = (i < wlog_b.size()) ? wlog_b[i] : 24'hxxxxxx;
      check($sformatf("%s_w%0d", tag, i), v, exp_b[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
    start_a = 1'b0; start_b = 1'b0; fen_b = 1'b1;
    rom_a[0] = 24'h370099; rom_a[1] = 24'h370147; rom_a[2] = 24'h3f0000; rom_a[3] = 24'hFFFF00;
    rom_b[0] = 24'h3900AA; rom_b[1] = 24'h390155; rom_b[2] = 24'h3b0012; rom_b[3] = 24'hFFFF00;

    // Reset state
    tick();
    check("rst_taddr", bus_a.table_address, 0);
    check("rst_caddr", bus_a.cpu_address, 0);
    check("rst_wdata", bus_a.write_data, 0);
    check("rst_we_b", bus_a.write_enable_B, 1);
    check("rst_trst", trst_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_mm", mm_a, 0);

    // Basic auto-started sequence: 3 entries x 4 + sentinel 2 = 14 cycles
    rst_a = 1'b1;
    tick();
    check("a_busy_e0", busy_a, 1);
    check("a_trst_e0", trst_a, 1);
    tick(2);
    check("a_we_e2", bus_a.write_enable_B, 0);
    check("a_addr_e2", bus_a.cpu_address, 16'h3700);
    check("a_data_e2", bus_a.write_data, 8'h99);
    tick();
    check("a_we_e3", bus_a.write_enable_B, 1);
    tick(10);
    check("a_done_e13", done_a, 0);
    tick();
    check("a_done_e14", done_a, 1);
    check("a_trst_e14", trst_a, 0);
    check("a_busy_e14", busy_a, 0);
    check("a_err_e14", err_a, 0);
    check("a_we_idle", bus_a.write_enable_B, 1);
    check_log_a("a_basic");

    // clk_enable 1-0-0-1 during the first WRITE
    wlog_a.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(2);
    check("g_we_write", bus_a.write_enable_B, 0);
    en_a = 1'b0;
    tick();
    check("g_we_stall1", bus_a.write_enable_B, 0);
    tick();
    check("g_we_stall2", bus_a.write_enable_B, 0);
    check("g_addr_stall", bus_a.cpu_address, 16'h3700);
    en_a = 1'b1;
    wait_done(1'b0, n);
    check("g_cycles", n, 12);
    check_log_a("g_log");

    // Reset asserted during the second entry's WRITE
    wlog_a.delete();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(6);
    check("r_we_entry2", bus_a.write_enable_B, 0);
    check("r_addr_entry2", bus_a.cpu_address, 16'h3701);
    #2 rst_a = 1'b0;
    #1;
    check("r_async_we", bus_a.write_enable_B, 1);
    check("r_async_addr", bus_a.cpu_address, 0);
    check("r_async_data", bus_a.write_data, 0);
    check("r_async_taddr", bus_a.table_address, 0);
    check("r_async_trst", trst_a, 1);
    check("r_async_busy", busy_a, 0);
    @(negedge clk_1);
    wlog_a.delete();
    rst_a = 1'b1;
    wait_done(1'b0, n);
    check("r_cycles", n, 15);
    check("r_err", err_a, 0);
    check_log_a("r_log");

    // DUT b: no auto start
    rst_b = 1'b1;
    tick(3);
    check("b_idle_busy", busy_b, 0);
    check("b_idle_trst", trst_b, 1);
    check("b_idle_done", done_b, 0);

    // Verify run with one bad read-back, plus a start pulse while busy
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("v_busy_e0", busy_b, 1);
    tick(2);
    check("v_we_e2", bus_b.write_enable_B, 0);
    check("v_addr_e2", bus_b.cpu_address, 16'h3900);
    check("v_data_e2", bus_b.write_data, 8'hAA);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("v_we_read", bus_b.write_enable_B, 1);
    check("v_addr_read", bus_b.cpu_address, 16'h3900);
    wait_done(1'b1, n);
    check("v_cycles", n, 17);
    check("v_mm", mm_b, 1);
    check("v_err", err_b, 0);
    check("v_trst", trst_b, 0);
    check_log_b("v_log");

    // Restart after done: clears status and replays identically
    wlog_b.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("s_done_clr", done_b, 0);
    check("s_mm_clr", mm_b, 0);
    check("s_trst", trst_b, 1);
    check("s_busy", busy_b, 1);
    wait_done(1'b1, n);
    check("s_cycles", n, 20);
    check("s_mm", mm_b, 1);
    check_log_b("s_log");

    // Target never drives data: every entry mismatches
    rom_b[0] = 24'h3900AA; rom_b[1] = 24'h3b0012; rom_b[2] = 24'hFFFF00;
    fen_b = 1'b0;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1'b1, n);
    check("f_cycles", n, 14);
    check("f_mm", mm_b, 2);
    fen_b = 1'b1;

    // Table overrun: no sentinel in 4 entries
    rom_b[0] = 24'h370001; rom_b[1] = 24'h370102; rom_b[2] = 24'h370203; rom_b[3] = 24'h370304;
    wlog_b.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_done(1'b1, n);
    check("o_cycles", n, 24);
    check("o_err", err_b, 1);
    check("o_done", done_b, 1);
    check("o_taddr", bus_b.table_address, 3);
    check("o_writes", wlog_b.size(), 4);
    check("o_mm", mm_b, 0);

    // Empty table: sentinel at entry 0
    rom_b[0] = 24'hFFFF00;
    wlog_b.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    check("e_err_clr", err_b, 0);
    wait_done(1'b1, n);
    check("e_cycles", n, 2);
    check("e_writes", wlog_b.size(), 0);
    check("e_err", err_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
